// File: rtl/cam_table_pkg.sv
// cam_table_pkg
//   Shared definitions for the MAC-learning CAM family.
//   - Width helpers so every table variant derives its widths the same way.
//   - Default-configuration widths and entry layout (48-bit key, 32 entries,
//     8 egress ports, 4-bit age).
package cam_table_pkg;

    localparam int unsigned DEF_KEY_WIDTH   = 48;
    localparam int unsigned DEF_TABLE_DEPTH = 32;
    localparam int unsigned DEF_INDEX_DEPTH = 8;
    localparam int unsigned DEF_AGE_WIDTH   = 4;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Largest value an age counter of the given width can hold.
    function automatic int unsigned age_max(input int unsigned width);
        return (1 << width) - 1;
    endfunction

    localparam int unsigned INDEX_WIDTH = $clog2(DEF_INDEX_DEPTH);
    localparam int unsigned COUNT_WIDTH = count_width(DEF_TABLE_DEPTH);
    localparam int unsigned AGE_MAX     = age_max(DEF_AGE_WIDTH);

    typedef struct packed {
        logic                     valid;
        logic [DEF_KEY_WIDTH-1:0] key;
        logic [INDEX_WIDTH-1:0]   index;
        logic [DEF_AGE_WIDTH-1:0] age;
    } cam_entry_t;

endpackage

// File: rtl/cam_free_slot_encoder.sv
// cam_free_slot_encoder
//   Combinational lowest-set-bit priority encoder over a free-slot mask.
//   Ports:
//     free_mask  in   DEPTH             1 = slot is free
//     free_slot  out  $clog2(DEPTH)     lowest-numbered free slot (0 if none)
//     any_free   out  1                 at least one slot is free
module cam_free_slot_encoder #(
    parameter int unsigned DEPTH = 32
) (
    input  logic [DEPTH-1:0]         free_mask,
    output logic [$clog2(DEPTH)-1:0] free_slot,
    output logic                     any_free
);

    localparam int unsigned SLOT_W = $clog2(DEPTH);

    always_comb begin
        free_slot = '0;
        any_free  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (free_mask[i] && !any_free) begin
                free_slot = SLOT_W'(i);
                any_free  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_table_aging.sv
// cam_table_aging
//   MAC-learning CAM with station-move update, per-entry aging, flush,
//   full-table drop reporting and occupancy count. Lookups answer one cycle
//   later against the table contents at the start of the request cycle.
//   Ports:
//     clock, reset                 rising-edge clock, synchronous active-high reset
//     learn_valid/key/index        learn request (key -> egress index)
//     lookup_valid/key             lookup request
//     aging_enable                 run the age-tick prescaler
//     flush                        invalidate every entry
//     match_valid / no_match       one-cycle hit / miss pulse for last lookup
//     match_index                  index of last hit, held between hits
//     learn_dropped                one-cycle pulse: last learn found table full
//     entry_count                  number of valid entries
module cam_table_aging
    import cam_table_pkg::*;
#(
    parameter int unsigned KEY_WIDTH       = 48,
    parameter int unsigned TABLE_DEPTH     = 32,
    parameter int unsigned INDEX_DEPTH     = 8,
    parameter int unsigned AGE_WIDTH       = 4,
    parameter int unsigned AGE_TICK_CYCLES = 1000000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               learn_valid,
    input  logic [KEY_WIDTH-1:0]               learn_key,
    input  logic [$clog2(INDEX_DEPTH)-1:0]     learn_index,
    input  logic                               lookup_valid,
    input  logic [KEY_WIDTH-1:0]               lookup_key,
    input  logic                               aging_enable,
    input  logic                               flush,
    output logic                               match_valid,
    output logic                               no_match,
    output logic [$clog2(INDEX_DEPTH)-1:0]     match_index,
    output logic                               learn_dropped,
    output logic [$clog2(TABLE_DEPTH+1)-1:0]   entry_count
);

    localparam int unsigned IDX_W  = $clog2(INDEX_DEPTH);
    localparam int unsigned CNT_W  = count_width(TABLE_DEPTH);
    localparam int unsigned SLOT_W = $clog2(TABLE_DEPTH);
    localparam int unsigned PRE_W  = $clog2(AGE_TICK_CYCLES);

    typedef struct packed {
        logic                 valid;
        logic [KEY_WIDTH-1:0] key;
        logic [IDX_W-1:0]     index;
        logic [AGE_WIDTH-1:0] age;
    } entry_t;

    entry_t table_q [TABLE_DEPTH];
    entry_t table_d [TABLE_DEPTH];

    logic [PRE_W-1:0]       prescaler;
    logic                   age_tick;

    logic [TABLE_DEPTH-1:0] valid_vec;
    logic [TABLE_DEPTH-1:0] learn_hit_vec;
    logic [TABLE_DEPTH-1:0] lookup_hit_vec;
    logic                   learn_hit;
    logic                   lookup_hit;
    logic [IDX_W-1:0]       lookup_hit_index;
    logic [SLOT_W-1:0]      free_slot;
    logic                   any_free;
    logic                   learn_dropped_d;
    logic [CNT_W-1:0]       count_d;

    assign age_tick = aging_enable && (prescaler == PRE_W'(AGE_TICK_CYCLES - 1));

    // Match vectors use the registered (start-of-cycle) table only.
    always_comb begin
        valid_vec        = '0;
        learn_hit_vec    = '0;
        lookup_hit_vec   = '0;
        lookup_hit_index = '0;
        for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
            valid_vec[i]      = table_q[i].valid;
            learn_hit_vec[i]  = table_q[i].valid && (table_q[i].key == learn_key);
            lookup_hit_vec[i] = table_q[i].valid && (table_q[i].key == lookup_key);
            // Keys are unique, so at most one term contributes.
            if (lookup_hit_vec[i]) begin
                lookup_hit_index = lookup_hit_index | table_q[i].index;
            end
        end
    end

    assign learn_hit  = |learn_hit_vec;
    assign lookup_hit = |lookup_hit_vec;

    cam_free_slot_encoder #(
        .DEPTH (TABLE_DEPTH)
    ) u_free_slot (
        .free_mask (~valid_vec),
        .free_slot (free_slot),
        .any_free  (any_free)
    );

    // Next table state. Aging is applied first and then overridden by a
    // learn on the same entry, which gives learn priority over age_tick.
    always_comb begin
        learn_dropped_d = 1'b0;
        for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        if (flush) begin
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                table_d[i].valid = 1'b0;
            end
        end else begin
            if (age_tick) begin
                for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                    if (table_q[i].valid) begin
                        if (&table_q[i].age) begin
                            table_d[i].valid = 1'b0;
                        end else begin
                            table_d[i].age = table_q[i].age + AGE_WIDTH'(1);
                        end
                    end
                end
            end
            if (learn_valid) begin
                if (learn_hit) begin
                    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                        if (learn_hit_vec[i]) begin
                            table_d[i].valid = 1'b1;
                            table_d[i].index = learn_index;
                            table_d[i].age   = '0;
                        end
                    end
                end else if (any_free) begin
                    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                        if (SLOT_W'(i) == free_slot) begin
                            table_d[i].valid = 1'b1;
                            table_d[i].key   = learn_key;
                            table_d[i].index = learn_index;
                            table_d[i].age   = '0;
                        end
                    end
                end else begin
                    learn_dropped_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
            count_d = count_d + CNT_W'(table_d[i].valid);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                table_q[i] <= '0;
            end
            prescaler     <= '0;
            match_valid   <= 1'b0;
            no_match      <= 1'b0;
            match_index   <= '0;
            learn_dropped <= 1'b0;
            entry_count   <= '0;
        end else begin
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
            if (aging_enable) begin
                prescaler <= age_tick ? '0 : prescaler + PRE_W'(1);
            end
            match_valid   <= lookup_valid && lookup_hit;
            no_match      <= lookup_valid && !lookup_hit;
            if (lookup_valid && lookup_hit) begin
                match_index <= lookup_hit_index;
            end
            learn_dropped <= learn_dropped_d;
            entry_count   <= count_d;
        end
    end

endmodule
